cut_ctrl: RTL and testbench



---
 rtl/cut_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_cut_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cut_ctrl.sv
// Cut-window controller: host-programmable shadow registers, frame-synchronous
// commit into the active cut set, optional y sweep, and pixel position counters.
`timescale 1ns/1ps

module cut_ctrl #(
    parameter int unsigned H_ACTIVE   = 680,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned CUT_DEF    = 20,
    parameter int unsigned SWEEP_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_addr,
    input  logic [9:0] cfg_data,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic [9:0] xx,
    output logic [9:0] yy,
    output logic [9:0] x_cat,
    output logic [9:0] y_cut,
    output logic [9:0] cut_constant,
    output logic       update_pending,
    output logic       frame_done
);

    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - 2);
    localparam logic [9:0]  CUT_RST = 10'(CUT_DEF);
    localparam logic [10:0] X_LAST_W = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_MAX_W  = 11'(V_ACTIVE - 2);
    localparam logic [10:0] STEP_W   = 11'(SWEEP_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] xx_q, xx_d, yy_q, yy_d;
    logic [9:0] x_cat_q, x_cat_d, y_cut_q, y_cut_d, cut_q, cut_d;
    logic [9:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_w_q, sh_w_d;
    logic       sweep_en_q, sweep_en_d;
    logic       pend_q, pend_d;
    logic       take_q, take_d;
    logic       ack_q, ack_d, err_q, err_d, done_q, done_d;
    logic [10:0] x_sum, y_sum;

    assign x_sum = {1'b0, sh_x_q} + {1'b0, sh_w_q};
    assign y_sum = {1'b0, y_cut_q} + STEP_W;

    always_comb begin
        state_d    = state_q;
        xx_d       = xx_q;
        yy_d       = yy_q;
        x_cat_d    = x_cat_q;
        y_cut_d    = y_cut_q;
        cut_d      = cut_q;
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_w_d     = sh_w_q;
        sweep_en_d = sweep_en_q;
        pend_d     = pend_q;
        take_d     = take_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        done_d     = 1'b0;

        // take_q freezes the pending flag as seen at the frame_start edge, so a
        // commit landing on that same edge waits for the next frame.
        case (state_q)
            IDLE: begin
                xx_d = '0;
                yy_d = '0;
                if (frame_start) begin
                    state_d = APPLY;
                    take_d  = pend_q;
                end
            end
            APPLY: begin
                state_d = RUN;
                xx_d    = '0;
                yy_d    = '0;
                if (take_q) begin
                    x_cat_d = sh_x_q;
                    y_cut_d = sh_y_q;
                    cut_d   = (x_sum > X_LAST_W) ? (X_LAST - sh_x_q) : sh_w_q;
                    pend_d  = 1'b0;
                end else if (sweep_en_q) begin
                    y_cut_d = (y_sum > Y_MAX_W) ? '0 : y_sum[9:0];
                end
            end
            RUN: begin
                if (frame_start) begin
                    state_d = APPLY;
                    take_d  = pend_q;
                    xx_d    = '0;
                    yy_d    = '0;
                end else if (pix_valid) begin
                    if (xx_q == X_LAST) begin
                        xx_d = '0;
                        if (yy_q == Y_LAST) begin
                            yy_d    = '0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            yy_d = yy_q + 10'd1;
                        end
                    end else begin
                        xx_d = xx_q + 10'd1;
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    state_d = APPLY;
                    take_d  = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Host writes are evaluated last so a commit wins over the APPLY clear.
        if (cfg_wr) begin
            case (cfg_addr)
                2'd0: begin
                    if (cfg_data > X_LAST) err_d = 1'b1;
                    else begin
                        sh_x_d = cfg_data;
                        ack_d  = 1'b1;
                    end
                end
                2'd1: begin
                    if (cfg_data > Y_MAX) err_d = 1'b1;
                    else begin
                        sh_y_d = cfg_data;
                        ack_d  = 1'b1;
                    end
                end
                2'd2: begin
                    sh_w_d = cfg_data;
                    ack_d  = 1'b1;
                end
                default: begin
                    sweep_en_d = cfg_data[0];
                    if (cfg_data[1]) pend_d = 1'b1;
                    ack_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            xx_q       <= '0;
            yy_q       <= '0;
            x_cat_q    <= '0;
            y_cut_q    <= '0;
            cut_q      <= CUT_RST;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_w_q     <= CUT_RST;
            sweep_en_q <= 1'b0;
            pend_q     <= 1'b0;
            take_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xx_q       <= xx_d;
            yy_q       <= yy_d;
            x_cat_q    <= x_cat_d;
            y_cut_q    <= y_cut_d;
            cut_q      <= cut_d;
            sh_x_q     <= sh_x_d;
            sh_y_q     <= sh_y_d;
            sh_w_q     <= sh_w_d;
            sweep_en_q <= sweep_en_d;
            pend_q     <= pend_d;
            take_q     <= take_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign cfg_ack        = ack_q;
    assign cfg_err        = err_q;
    assign xx             = xx_q;
    assign yy             = yy_q;
    assign x_cat          = x_cat_q;
    assign y_cut          = y_cut_q;
    assign cut_constant   = cut_q;
    assign update_pending = pend_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_cut_ctrl.sv
// Directed bench for cut_ctrl: full-size instance for register/commit/sweep
// behaviour, plus a reduced-geometry instance for whole-frame counting.
`timescale 1ns/1ps

module tb_cut_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start, pix_valid, cfg_wr;
    logic [1:0] cfg_addr;
    logic [9:0] cfg_data;
    logic       cfg_ack, cfg_err, update_pending, frame_done;
    logic [9:0] xx, yy, x_cat, y_cut, cut_constant;

    logic       s_frame_start, s_pix_valid, s_cfg_wr;
    logic [1:0] s_cfg_addr;
    logic [9:0] s_cfg_data;
    logic       s_cfg_ack, s_cfg_err, s_update_pending, s_frame_done;
    logic [9:0] s_xx, s_yy, s_x_cat, s_y_cut, s_cut_constant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cut_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .xx(xx), .yy(yy),
        .x_cat(x_cat), .y_cut(y_cut), .cut_constant(cut_constant),
        .update_pending(update_pending), .frame_done(frame_done)
    );

    // 12x6 geometry keeps a complete frame short.
    cut_ctrl #(.H_ACTIVE(12), .V_ACTIVE(6), .CUT_DEF(3), .SWEEP_STEP(2)) u_small (
        .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start), .pix_valid(s_pix_valid),
        .cfg_wr(s_cfg_wr), .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data),
        .cfg_ack(s_cfg_ack), .cfg_err(s_cfg_err), .xx(s_xx), .yy(s_yy),
        .x_cat(s_x_cat), .y_cut(s_y_cut), .cut_constant(s_cut_constant),
        .update_pending(s_update_pending), .frame_done(s_frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [9:0] d,
                             output logic ack, output logic err);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
        ack      = cfg_ack;
        err      = cfg_err;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({xx, yy, x_cat, y_cut, cut_constant} !== {10'd0, 10'd0, 10'd0, 10'd0, 10'd20}) begin
            errors++;
            $display("FAIL reset_regs: xx=%0d yy=%0d x=%0d y=%0d w=%0d, want 0 0 0 0 20",
                     xx, yy, x_cat, y_cut, cut_constant);
        end
        checks++;
        if ({update_pending, cfg_ack, cfg_err, frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: pend/ack/err/done=%b, want 0000",
                     {update_pending, cfg_ack, cfg_err, frame_done});
        end
        checks++;
        if (s_cut_constant !== 10'd3) begin
            errors++;
            $display("FAIL reset_small_width: got %0d, want 3", s_cut_constant);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_commit_mid_frame();
        logic a, e;
        frame_pulse();
        pix_valid = 1'b1;
        repeat (5) tick();
        pix_valid = 1'b0;
        checks++;
        if (xx !== 10'd5 || yy !== 10'd0) begin
            errors++;
            $display("FAIL mid_count: xx=%0d yy=%0d, want 5 0", xx, yy);
        end
        cfg_write(2'd0, 10'd100, a, e);
        checks++;
        if (a !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_x_ack: ack=%b err=%b, want 1 0", a, e);
        end
        cfg_write(2'd1, 10'd200, a, e);
        cfg_write(2'd2, 10'd30, a, e);
        cfg_write(2'd3, 10'd2, a, e);
        checks++;
        if (update_pending !== 1'b1 || a !== 1'b1) begin
            errors++;
            $display("FAIL commit_pending: pend=%b ack=%b, want 1 1", update_pending, a);
        end
        repeat (3) tick();
        checks++;
        if ({x_cat, y_cut, cut_constant} !== {10'd0, 10'd0, 10'd20} || xx !== 10'd5) begin
            errors++;
            $display("FAIL commit_held: x=%0d y=%0d w=%0d xx=%0d, want 0 0 20 5",
                     x_cat, y_cut, cut_constant, xx);
        end
        frame_pulse();
        checks++;
        if ({x_cat, y_cut, cut_constant} !== {10'd100, 10'd200, 10'd30} || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL commit_apply: x=%0d y=%0d w=%0d pend=%b, want 100 200 30 0",
                     x_cat, y_cut, cut_constant, update_pending);
        end
    endtask

    task automatic test_clamp();
        logic a, e;
        cfg_write(2'd0, 10'd670, a, e);
        cfg_write(2'd2, 10'd30, a, e);
        cfg_write(2'd3, 10'd2, a, e);
        frame_pulse();
        checks++;
        if (x_cat !== 10'd670 || cut_constant !== 10'd9 || y_cut !== 10'd200) begin
            errors++;
            $display("FAIL clamp: x=%0d w=%0d y=%0d, want 670 9 200", x_cat, cut_constant, y_cut);
        end
    endtask

    task automatic test_reject();
        logic a, e;
        cfg_write(2'd0, 10'd680, a, e);
        checks++;
        if (a !== 1'b0 || e !== 1'b1) begin
            errors++;
            $display("FAIL reject_x680: ack=%b err=%b, want 0 1", a, e);
        end
        cfg_write(2'd1, 10'd479, a, e);
        checks++;
        if (a !== 1'b0 || e !== 1'b1) begin
            errors++;
            $display("FAIL reject_y479: ack=%b err=%b, want 0 1", a, e);
        end
        cfg_write(2'd3, 10'd2, a, e);
        frame_pulse();
        checks++;
        if (x_cat !== 10'd670 || y_cut !== 10'd200) begin
            errors++;
            $display("FAIL reject_shadow: x=%0d y=%0d, want 670 200", x_cat, y_cut);
        end
        cfg_write(2'd1, 10'd478, a, e);
        checks++;
        if (a !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL accept_y478: ack=%b err=%b, want 1 0", a, e);
        end
        cfg_write(2'd0, 10'd679, a, e);
        checks++;
        if (a !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL accept_x679: ack=%b err=%b, want 1 0", a, e);
        end
        cfg_write(2'd3, 10'd2, a, e);
        frame_pulse();
        checks++;
        if ({x_cat, y_cut, cut_constant} !== {10'd679, 10'd478, 10'd0}) begin
            errors++;
            $display("FAIL edge_apply: x=%0d y=%0d w=%0d, want 679 478 0", x_cat, y_cut, cut_constant);
        end
    endtask

    task automatic test_back_to_back();
        cfg_wr   = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = 10'd472;
        tick();
        checks++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: ack=%b err=%b, want 1 0", cfg_ack, cfg_err);
        end
        cfg_addr = 2'd0;
        cfg_data = 10'd700;
        tick();
        cfg_wr = 1'b0;
        checks++;
        if (cfg_ack !== 1'b0 || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: ack=%b err=%b, want 0 1", cfg_ack, cfg_err);
        end
        tick();
        checks++;
        if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: ack=%b err=%b, want 0 0", cfg_ack, cfg_err);
        end
    endtask

    task automatic test_sweep();
        logic a, e;
        logic [9:0] exp_y [3];
        exp_y[0] = 10'd476;
        exp_y[1] = 10'd0;
        exp_y[2] = 10'd4;
        cfg_write(2'd3, 10'd3, a, e);
        frame_pulse();
        checks++;
        if (y_cut !== 10'd472 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL sweep_commit: y=%0d pend=%b, want 472 0", y_cut, update_pending);
        end
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            checks++;
            if (y_cut !== exp_y[i] || x_cat !== 10'd679) begin
                errors++;
                $display("FAIL sweep_step%0d: y=%0d x=%0d, want %0d 679", i, y_cut, x_cat, exp_y[i]);
            end
        end
    endtask

    task automatic test_coincident();
        logic a, e;
        cfg_write(2'd1, 10'd100, a, e);
        frame_start = 1'b1;
        cfg_wr      = 1'b1;
        cfg_addr    = 2'd3;
        cfg_data    = 10'd3;
        tick();
        frame_start = 1'b0;
        cfg_wr      = 1'b0;
        checks++;
        if (cfg_ack !== 1'b1 || update_pending !== 1'b1) begin
            errors++;
            $display("FAIL coinc_ack: ack=%b pend=%b, want 1 1", cfg_ack, update_pending);
        end
        tick();
        checks++;
        if (y_cut !== 10'd8 || update_pending !== 1'b1) begin
            errors++;
            $display("FAIL coinc_sweep: y=%0d pend=%b, want 8 1", y_cut, update_pending);
        end
        frame_pulse();
        checks++;
        if (y_cut !== 10'd100 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL coinc_apply: y=%0d pend=%b, want 100 0", y_cut, update_pending);
        end
        frame_pulse();
        checks++;
        if (y_cut !== 10'd104) begin
            errors++;
            $display("FAIL coinc_resume: y=%0d, want 104", y_cut);
        end
    endtask

    task automatic test_truncated();
        pix_valid = 1'b1;
        repeat (10) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (xx !== 10'd0 || yy !== 10'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL trunc_restart: xx=%0d yy=%0d done=%b, want 0 0 0", xx, yy, frame_done);
        end
        tick();
        checks++;
        if (xx !== 10'd0) begin
            errors++;
            $display("FAIL apply_ignores_pix: xx=%0d, want 0", xx);
        end
        tick();
        pix_valid = 1'b0;
        checks++;
        if (xx !== 10'd1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL trunc_resume: xx=%0d done=%b, want 1 0", xx, frame_done);
        end
    endtask

    task automatic test_full_frame();
        int n = 0;
        int c = 0;
        int done_cnt = 0;
        int done_at = -1;
        s_frame_start = 1'b1;
        tick();
        s_frame_start = 1'b0;
        tick();
        while (n < 72 && c < 200) begin
            s_pix_valid = (c % 4 != 3);
            tick();
            if (s_pix_valid) n++;
            if (s_frame_done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
            if (n == 13 && s_pix_valid) begin
                checks++;
                if (s_xx !== 10'd1 || s_yy !== 10'd1) begin
                    errors++;
                    $display("FAIL frame_wrap: xx=%0d yy=%0d, want 1 1", s_xx, s_yy);
                end
            end
            c++;
        end
        checks++;
        if (n != 72) begin
            errors++;
            $display("FAIL frame_budget: sent %0d pixels, want 72", n);
        end
        s_pix_valid = 1'b1;
        repeat (3) begin
            tick();
            if (s_frame_done === 1'b1) done_cnt++;
        end
        s_pix_valid = 1'b0;
        checks++;
        if (done_cnt != 1 || done_at != 72) begin
            errors++;
            $display("FAIL frame_done: pulses=%0d at=%0d, want 1 at 72", done_cnt, done_at);
        end
        checks++;
        if (s_xx !== 10'd0 || s_yy !== 10'd0) begin
            errors++;
            $display("FAIL done_holds: xx=%0d yy=%0d, want 0 0", s_xx, s_yy);
        end
        s_frame_start = 1'b1;
        tick();
        s_frame_start = 1'b0;
        tick();
        s_pix_valid = 1'b1;
        tick();
        s_pix_valid = 1'b0;
        checks++;
        if (s_xx !== 10'd1) begin
            errors++;
            $display("FAIL next_frame: xx=%0d, want 1", s_xx);
        end
    endtask

    task automatic test_reset_mid();
        logic a, e;
        cfg_write(2'd0, 10'd5, a, e);
        cfg_write(2'd3, 10'd2, a, e);
        pix_valid = 1'b1;
        repeat (4) tick();
        pix_valid = 1'b0;
        cfg_wr    = 1'b1;
        cfg_addr  = 2'd0;
        cfg_data  = 10'd7;
        rst_n     = 1'b0;
        #2;
        checks++;
        if ({update_pending, cfg_ack, xx, x_cat, y_cut, cut_constant} !==
            {1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd20}) begin
            errors++;
            $display("FAIL async_reset: pend=%b ack=%b xx=%0d x=%0d y=%0d w=%0d, want 0 0 0 0 0 20",
                     update_pending, cfg_ack, xx, x_cat, y_cut, cut_constant);
        end
        cfg_wr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_wr: ack=%b err=%b, want 0 0", cfg_ack, cfg_err);
        end
        pix_valid = 1'b1;
        repeat (3) tick();
        pix_valid = 1'b0;
        checks++;
        if (xx !== 10'd0) begin
            errors++;
            $display("FAIL idle_ignores_pix: xx=%0d, want 0", xx);
        end
        frame_pulse();
        checks++;
        if ({x_cat, y_cut, cut_constant, 1'b0} !== {10'd0, 10'd0, 10'd20, update_pending}) begin
            errors++;
            $display("FAIL reset_discard: x=%0d y=%0d w=%0d pend=%b, want 0 0 20 0",
                     x_cat, y_cut, cut_constant, update_pending);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        frame_start   = 1'b0;
        pix_valid     = 1'b0;
        cfg_wr        = 1'b0;
        cfg_addr      = 2'd0;
        cfg_data      = 10'd0;
        s_frame_start = 1'b0;
        s_pix_valid   = 1'b0;
        s_cfg_wr      = 1'b0;
        s_cfg_addr    = 2'd0;
        s_cfg_data    = 10'd0;
        #2;
        test_reset();
        test_commit_mid_frame();
        test_clamp();
        test_reject();
        test_back_to_back();
        test_sweep();
        test_coincident();
        test_truncated();
        test_full_frame();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
